// File: rtl/alu_nbit_sekuencial.sv
// WIDTH-bit ALU with valid/ready on both sides: logic/ADD/SLT in one cycle, shifts and MUL iterate.
// Latency 1 (single-cycle ops, zero shifts), n+1 (shift by n) or WIDTH+1 (MUL); Result held until OutReady.
module alu_nbit_sekuencial #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             BInvert,
  input  logic [2:0]       Op,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [SHW:0]     cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, neg_q, carry_q, ovf_q;
  logic             out_valid_q, in_ready_q;

  logic [WIDTH-1:0] mb;
  logic [WIDTH:0]   sum, diff;
  logic             slt_ovf;
  logic [WIDTH-1:0] sc_res_d;
  logic             sc_c_d, sc_v_d;
  logic             zero_shift;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] shift_d, busy_res_d;
  logic             busy_v_d;

  // Single-cycle datapath, evaluated directly on the request operands.
  always_comb begin
    mb       = BInvert ? ~B : B;
    sum      = {1'b0, A} + {1'b0, mb} + {{WIDTH{1'b0}}, CIN};
    diff     = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    slt_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    sc_res_d = A;
    sc_c_d   = 1'b0;
    sc_v_d   = 1'b0;
    case (Op)
      OP_AND: sc_res_d = A & mb;
      OP_OR:  sc_res_d = A | mb;
      OP_XOR: sc_res_d = A ^ mb;
      OP_ADD: begin
        sc_res_d = sum[WIDTH-1:0];
        sc_c_d   = sum[WIDTH];
        sc_v_d   = (A[WIDTH-1] == mb[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: begin
        sc_res_d = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ slt_ovf};
        sc_c_d   = diff[WIDTH];
      end
      default: sc_res_d = A;
    endcase
    zero_shift = ((Op == OP_SLL) || (Op == OP_SRL)) && (B[SHW-1:0] == '0);
  end

  // Iterative step: {hi,lo} is the shift-add product register; lo doubles as the shift register.
  always_comb begin
    mul_sum    = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : {WIDTH{1'b0}})};
    shift_d    = (op_q == OP_SLL) ? (lo_q << 1) : (lo_q >> 1);
    busy_res_d = shift_d;
    busy_v_d   = 1'b0;
    if (op_q == OP_MUL) begin
      busy_res_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      busy_v_d   = |mul_sum[WIDTH:1];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      op_q        <= OP_AND;
      a_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (InValid) begin
            op_q       <= Op;
            a_q        <= A;
            in_ready_q <= 1'b0;
            if (!Op[2] || (Op == OP_SLT) || zero_shift) begin
              result_q    <= sc_res_d;
              zero_q      <= (sc_res_d == '0);
              neg_q       <= sc_res_d[WIDTH-1];
              carry_q     <= sc_c_d;
              ovf_q       <= sc_v_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (Op == OP_MUL) begin
              hi_q    <= '0;
              lo_q    <= B;
              cnt_q   <= (SHW+1)'(WIDTH);
              state_q <= BUSY;
            end else begin
              lo_q    <= A;
              cnt_q   <= {1'b0, B[SHW-1:0]};
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (op_q == OP_MUL) begin
            hi_q <= mul_sum[WIDTH:1];
            lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
          end else begin
            lo_q <= shift_d;
          end
          cnt_q <= cnt_q - (SHW+1)'(1);
          if (cnt_q == (SHW+1)'(1)) begin
            result_q    <= busy_res_d;
            zero_q      <= (busy_res_d == '0);
            neg_q       <= busy_res_d[WIDTH-1];
            carry_q     <= 1'b0;
            ovf_q       <= busy_v_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (OutReady) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Negative = neg_q;
  assign CarryOut = carry_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_nbit_sekuencial.sv
// Scoreboard bench for alu_nbit_sekuencial at WIDTH=16: expected outputs come from a behavioural model.
module tb_alu_nbit_sekuencial;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z, n, c, v;
    logic [7:0]   lat;
  } out_t;

  logic         Clock = 1'b0;
  logic         Reset_n, InValid, InReady, CIN, BInvert, OutValid, OutReady;
  logic         Zero, Negative, CarryOut, Overflow;
  logic [W-1:0] A, B, Result;
  logic [2:0]   Op;

  int   checks = 0;
  int   errors = 0;
  out_t sb[$];

  alu_nbit_sekuencial #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .CIN(CIN), .BInvert(BInvert), .Op(Op),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
    .Zero(Zero), .Negative(Negative), .CarryOut(CarryOut), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  function automatic out_t model(input logic [2:0] op, input logic [W-1:0] a, b,
                                 input logic cin, binv);
    out_t         e;
    logic [W-1:0] mb;
    int           u, s;
    logic [31:0]  p;
    mb = binv ? ~b : b;
    e = '0;
    e.lat = 8'd1;
    case (op)
      3'd0: e.res = a & mb;
      3'd1: e.res = a | mb;
      3'd2: e.res = a ^ mb;
      3'd3: begin
        u = int'(a) + int'(mb) + int'(cin);
        s = int'($signed(a)) + int'($signed(mb)) + int'(cin);
        e.res = u[W-1:0];
        e.c = (u > 65535);
        e.v = (s > 32767) || (s < -32768);
      end
      3'd4: begin
        e.res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
        e.c = (a >= b);
      end
      3'd5: begin e.res = a << b[3:0]; e.lat = 8'(b[3:0]) + 8'd1; end
      3'd6: begin e.res = a >> b[3:0]; e.lat = 8'(b[3:0]) + 8'd1; end
      default: begin
        p = 32'(a) * 32'(b);
        e.res = p[W-1:0];
        e.v = (p >= 32'h10000);
        e.lat = 8'(W + 1);
      end
    endcase
    e.z = (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("res=%h z=%b n=%b c=%b v=%b lat=%0d", o.res, o.z, o.n, o.c, o.v, o.lat);
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b, input logic cin, binv);
    @(negedge Clock);
    Op = op; A = a; B = b; CIN = cin; BInvert = binv; InValid = 1'b1;
    sb.push_back(model(op, a, b, cin, binv));
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    A = W'($urandom); B = W'($urandom); CIN = 1'($urandom); BInvert = 1'($urandom);
  endtask

  task automatic collect(output out_t o);
    int lat;
    @(negedge Clock);
    lat = 1;
    while (OutValid !== 1'b1 && lat < 200) begin
      @(negedge Clock);
      lat++;
    end
    o = {Result, Zero, Negative, CarryOut, Overflow, 8'(lat)};
  endtask

  task automatic take_result();
    OutReady = 1'b1;
    @(negedge Clock);
    OutReady = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Op = 3'd0; A = '0; B = '0; CIN = 1'b0; BInvert = 1'b0;
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    checks++;
    if ({OutValid, InReady, Result, Zero, Negative, CarryOut, Overflow} !== {1'b0, 1'b1, 16'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state: ov=%b ir=%b res=%h flags=%b%b%b%b, expected ov=0 ir=1 res=0000 flags=0000",
               OutValid, InReady, Result, Zero, Negative, CarryOut, Overflow);
    end
  endtask

  task automatic test_add_sub();
    out_t o, e;
    issue(3'd3, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    collect(o); e = sb.pop_front();
    checks++;
    if (o !== e || e.res !== 16'h8000 || e.v !== 1'b1) begin
      errors++; $display("FAIL add_ovf: got %s expected %s", fmt(o), fmt(e));
    end
    take_result();
    issue(3'd3, 16'h0005, 16'h0005, 1'b1, 1'b1);
    collect(o); e = sb.pop_front();
    checks++;
    if (o !== e || e.res !== 16'h0000 || e.c !== 1'b1) begin
      errors++; $display("FAIL sub_zero: got %s expected %s", fmt(o), fmt(e));
    end
    take_result();
  endtask

  task automatic test_slt();
    out_t o, e;
    logic [W-1:0] av[2] = '{16'hFFFF, 16'h0001};
    logic [W-1:0] bv[2] = '{16'h0001, 16'hFFFF};
    logic [W-1:0] rv[2] = '{16'h0001, 16'h0000};
    for (int i = 0; i < 2; i++) begin
      issue(3'd4, av[i], bv[i], 1'b1, 1'b1);
      collect(o); e = sb.pop_front();
      checks++;
      if (o !== e || e.res !== rv[i]) begin
        errors++; $display("FAIL slt_%0d: got %s expected %s", i, fmt(o), fmt(e));
      end
      take_result();
    end
  endtask

  task automatic test_shift();
    out_t o, e;
    issue(3'd5, 16'h0001, 16'h000F, 1'b0, 1'b0);
    collect(o); e = sb.pop_front();
    checks++;
    if (o !== e || e.res !== 16'h8000 || e.lat !== 8'd16) begin
      errors++; $display("FAIL sll_15: got %s expected %s", fmt(o), fmt(e));
    end
    take_result();
    issue(3'd6, 16'h8000, 16'h0000, 1'b0, 1'b0);
    collect(o); e = sb.pop_front();
    checks++;
    if (o !== e || e.lat !== 8'd1) begin
      errors++; $display("FAIL srl_0: got %s expected %s", fmt(o), fmt(e));
    end
    take_result();
    issue(3'd6, 16'hF0F0, 16'hFFF3, 1'b0, 1'b0);
    collect(o); e = sb.pop_front();
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL srl_3: got %s expected %s", fmt(o), fmt(e));
    end
    take_result();
  endtask

  task automatic test_mul();
    out_t o, e;
    issue(3'd7, 16'h00FF, 16'h0101, 1'b1, 1'b1);
    collect(o); e = sb.pop_front();
    checks++;
    if (o !== e || e.res !== 16'hFFFF || e.lat !== 8'd17) begin
      errors++; $display("FAIL mul_ffff: got %s expected %s", fmt(o), fmt(e));
    end
    take_result();
    issue(3'd7, 16'h0100, 16'h0100, 1'b0, 1'b0);
    collect(o); e = sb.pop_front();
    checks++;
    if (o !== e || e.z !== 1'b1 || e.v !== 1'b1) begin
      errors++; $display("FAIL mul_ovf: got %s expected %s", fmt(o), fmt(e));
    end
    take_result();
  endtask

  task automatic test_backpressure();
    out_t o, e;
    issue(3'd3, 16'h1234, 16'h1111, 1'b0, 1'b0);
    collect(o); e = sb.pop_front();
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL bp_result: got %s expected %s", fmt(o), fmt(e));
    end
    for (int i = 0; i < 3; i++) begin
      InValid = (i == 1); Op = 3'd0; A = 16'h0; B = 16'h0;
      @(negedge Clock);
      checks++;
      if ({OutValid, InReady, Result, Zero, Negative, CarryOut, Overflow} !==
          {1'b1, 1'b0, e.res, e.z, e.n, e.c, e.v}) begin
        errors++;
        $display("FAIL bp_hold_%0d: ov=%b ir=%b res=%h, expected ov=1 ir=0 res=%h", i, OutValid, InReady, Result, e.res);
      end
    end
    InValid = 1'b0;
    take_result();
    checks++;
    if ({OutValid, InReady} !== 2'b01) begin
      errors++; $display("FAIL bp_release: ov=%b ir=%b, expected ov=0 ir=1", OutValid, InReady);
    end
    repeat (3) @(negedge Clock);
    checks++;
    if (OutValid !== 1'b0) begin
      errors++; $display("FAIL bp_ignored_invalid: ov=%b expected 0", OutValid);
    end
  endtask

  task automatic test_reset_mid_mul();
    out_t o, e;
    issue(3'd7, 16'h00FF, 16'h0101, 1'b0, 1'b0);
    void'(sb.pop_back());
    repeat (7) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    checks++;
    if ({OutValid, Result, InReady} !== {1'b0, 16'h0, 1'b1}) begin
      errors++; $display("FAIL mid_mul_reset: ov=%b res=%h ir=%b, expected ov=0 res=0000 ir=1", OutValid, Result, InReady);
    end
    issue(3'd3, 16'h0002, 16'h0003, 1'b0, 1'b0);
    collect(o); e = sb.pop_front();
    checks++;
    if (o !== e || e.res !== 16'h0005) begin
      errors++; $display("FAIL add_after_reset: got %s expected %s", fmt(o), fmt(e));
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    out_t o, e;
    for (int i = 0; i < 24; i++) begin
      issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      collect(o); e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL rand_%0d op=%0d: got %s expected %s", i, Op, fmt(o), fmt(e));
      end
      take_result();
      checks++;
      if ({OutValid, InReady} !== 2'b01) begin
        errors++; $display("FAIL rand_%0d_idle: ov=%b ir=%b, expected ov=0 ir=1", i, OutValid, InReady);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_slt();
    test_shift();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
